// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hazard-driven bubble insertion, PC / IF-ID write
// enables, a saturating stall counter and a sticky long-stall watchdog.
module id_ex_stage_reg (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Nop,
    input  logic         Flush,
    input  logic         ID_valid,
    input  logic [7:0]   ctrl_ID,
    input  logic [4:0]   rfReSel1_ID,
    input  logic [4:0]   rfReSel2_ID,
    input  logic [4:0]   rfWeSel_ID,
    input  logic [127:0] data_ID,
    output logic         EX_valid,
    output logic [7:0]   ctrl_EX,
    output logic [4:0]   EX_rfReSel1,
    output logic [4:0]   EX_rfReSel2,
    output logic [4:0]   EX_rfWeSel,
    output logic [127:0] data_EX,
    output logic         pcWe,
    output logic         ifidWe,
    output logic [7:0]   stall_cnt,
    output logic         stall_err
);

    localparam logic [7:0] CntMax = 8'hFF;

    typedef enum logic [2:0] {
        StRun,
        StStall1,
        StStall2,
        StStall3,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic         ex_valid_q, ex_valid_d;
    logic [7:0]   ctrl_q, ctrl_d;
    logic [4:0]   re_sel1_q, re_sel1_d;
    logic [4:0]   re_sel2_q, re_sel2_d;
    logic [4:0]   we_sel_q, we_sel_d;
    logic [127:0] data_q, data_d;
    logic [7:0]   stall_cnt_q, stall_cnt_d;
    logic         stall_err_q, stall_err_d;

    // Flush wins over Nop: a redirect squashes ID but must not freeze the front end.
    logic bubble;
    logic squash;
    logic err_set;

    assign bubble = Nop & ~Flush;
    assign squash = Nop | Flush;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: consecutive bubble cycles walk toward ERR, anything else returns to RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    state_d = bubble ? StStall1 : StRun;
            StStall1: state_d = bubble ? StStall2 : StRun;
            StStall2: state_d = bubble ? StStall3 : StRun;
            StStall3: state_d = bubble ? StErr    : StRun;
            StErr:    state_d = StErr;
            default:  state_d = StRun;
        endcase
    end

    // FSM outputs: write enables drop only on a bubble; reset keeps the front end running.
    always_comb begin
        pcWe    = 1'b1;
        ifidWe  = 1'b1;
        err_set = 1'b0;
        if (rst_n && bubble) begin
            pcWe   = 1'b0;
            ifidWe = 1'b0;
        end
        if (state_q == StStall3 && bubble) begin
            err_set = 1'b1;
        end
    end

    // Pipeline next state: squashed cycles load an all-zero bubble (no RegWe, no MemW).
    always_comb begin
        ex_valid_d = ID_valid;
        ctrl_d     = ctrl_ID;
        re_sel1_d  = rfReSel1_ID;
        re_sel2_d  = rfReSel2_ID;
        we_sel_d   = rfWeSel_ID;
        data_d     = data_ID;
        if (squash) begin
            ex_valid_d = 1'b0;
            ctrl_d     = '0;
            re_sel1_d  = '0;
            re_sel2_d  = '0;
            we_sel_d   = '0;
            data_d     = '0;
        end
    end

    // ID/EX pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            re_sel1_q  <= '0;
            re_sel2_q  <= '0;
            we_sel_q   <= '0;
            data_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ctrl_q     <= ctrl_d;
            re_sel1_q  <= re_sel1_d;
            re_sel2_q  <= re_sel2_d;
            we_sel_q   <= we_sel_d;
            data_q     <= data_d;
        end
    end

    // Stall statistics next state: count bubble cycles with saturation, latch the watchdog.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble && stall_cnt_q != CntMax) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
        stall_err_d = stall_err_q | err_set;
    end

    // Stall statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign EX_valid    = ex_valid_q;
    assign ctrl_EX     = ctrl_q;
    assign EX_rfReSel1 = re_sel1_q;
    assign EX_rfReSel2 = re_sel2_q;
    assign EX_rfWeSel  = we_sel_q;
    assign data_EX     = data_q;
    assign stall_cnt   = stall_cnt_q;
    assign stall_err   = stall_err_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg with hand-computed expected values.
module tb_id_ex_stage_reg;

    logic         clk;
    logic         rst_n;
    logic         Nop;
    logic         Flush;
    logic         ID_valid;
    logic [7:0]   ctrl_ID;
    logic [4:0]   rfReSel1_ID;
    logic [4:0]   rfReSel2_ID;
    logic [4:0]   rfWeSel_ID;
    logic [127:0] data_ID;
    logic         EX_valid;
    logic [7:0]   ctrl_EX;
    logic [4:0]   EX_rfReSel1;
    logic [4:0]   EX_rfReSel2;
    logic [4:0]   EX_rfWeSel;
    logic [127:0] data_EX;
    logic         pcWe;
    logic         ifidWe;
    logic [7:0]   stall_cnt;
    logic         stall_err;

    int checks;
    int errors;

    localparam logic [127:0] DataA = {32'h0000_0040, 32'h0000_0010, 32'h0000_5678, 32'h0000_1234};
    localparam logic [127:0] DataB = {32'h0000_0044, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hCAFE_0001};

    id_ex_stage_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Nop         (Nop),
        .Flush       (Flush),
        .ID_valid    (ID_valid),
        .ctrl_ID     (ctrl_ID),
        .rfReSel1_ID (rfReSel1_ID),
        .rfReSel2_ID (rfReSel2_ID),
        .rfWeSel_ID  (rfWeSel_ID),
        .data_ID     (data_ID),
        .EX_valid    (EX_valid),
        .ctrl_EX     (ctrl_EX),
        .EX_rfReSel1 (EX_rfReSel1),
        .EX_rfReSel2 (EX_rfReSel2),
        .EX_rfWeSel  (EX_rfWeSel),
        .data_EX     (data_EX),
        .pcWe        (pcWe),
        .ifidWe      (ifidWe),
        .stall_cnt   (stall_cnt),
        .stall_err   (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [7:0] c, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [4:0] wd, input logic [127:0] d);
        ID_valid    = v;
        ctrl_ID     = c;
        rfReSel1_ID = s1;
        rfReSel2_ID = s2;
        rfWeSel_ID  = wd;
        data_ID     = d;
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_valid"}, 128'(EX_valid), 128'(0));
        check_eq({tag, "_ctrl"}, 128'(ctrl_EX), 128'(0));
        check_eq({tag, "_sels"}, 128'({EX_rfReSel1, EX_rfReSel2, EX_rfWeSel}), 128'(0));
        check_eq({tag, "_data"}, data_EX, 128'(0));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        Nop    = 1'b1;
        Flush  = 1'b0;
        drive_id(1'b1, 8'hC0, 5'd3, 5'd4, 5'd8, DataA);

        // Reset state, with Nop high to confirm enables stay on during reset.
        #3;
        check_bubble("rst");
        check_eq("rst_pcwe", 128'(pcWe), 128'(1));
        check_eq("rst_ifidwe", 128'(ifidWe), 128'(1));
        check_eq("rst_cnt", 128'(stall_cnt), 128'(0));
        check_eq("rst_err", 128'(stall_err), 128'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        Nop   = 1'b0;

        // Normal load.
        #1;
        check_eq("norm_pcwe", 128'({pcWe, ifidWe}), 128'(2'b11));
        tick();
        check_eq("norm_valid", 128'(EX_valid), 128'(1));
        check_eq("norm_ctrl", 128'(ctrl_EX), 128'(8'hC0));
        check_eq("norm_wesel", 128'(EX_rfWeSel), 128'(8));
        check_eq("norm_resel", 128'({EX_rfReSel1, EX_rfReSel2}), 128'({5'd3, 5'd4}));
        check_eq("norm_rd1", 128'(data_EX[31:0]), 128'(32'h1234));
        check_eq("norm_data", data_EX, DataA);

        // Second distinct pattern, ID_valid low passes straight through.
        drive_id(1'b0, 8'h3A, 5'd31, 5'd17, 5'd0, DataB);
        tick();
        check_eq("norm2_valid", 128'(EX_valid), 128'(0));
        check_eq("norm2_ctrl", 128'(ctrl_EX), 128'(8'h3A));
        check_eq("norm2_data", data_EX, DataB);

        // Load-use: single Nop cycle.
        drive_id(1'b1, 8'hE4, 5'd1, 5'd2, 5'd5, DataA);
        Nop = 1'b1;
        #1;
        check_eq("lu_pcwe", 128'(pcWe), 128'(0));
        check_eq("lu_ifidwe", 128'(ifidWe), 128'(0));
        tick();
        check_bubble("lu");
        check_eq("lu_cnt", 128'(stall_cnt), 128'(1));
        Nop = 1'b0;
        #1;
        check_eq("lu_release_pcwe", 128'(pcWe), 128'(1));
        tick();
        check_eq("lu_resume_ctrl", 128'(ctrl_EX), 128'(8'hE4));

        // Nop and Flush together: flush wins, no stall count.
        Nop   = 1'b1;
        Flush = 1'b1;
        #1;
        check_eq("nf_we", 128'({pcWe, ifidWe}), 128'(2'b11));
        tick();
        check_bubble("nf");
        check_eq("nf_cnt", 128'(stall_cnt), 128'(1));

        // Flush alone also bubbles without stalling.
        Nop = 1'b0;
        tick();
        check_eq("fl_valid", 128'(EX_valid), 128'(0));
        Flush = 1'b0;

        // Nop with ID_valid low still stalls and counts.
        ID_valid = 1'b0;
        Nop      = 1'b1;
        #1;
        check_eq("nv_pcwe", 128'(pcWe), 128'(0));
        tick();
        check_eq("nv_cnt", 128'(stall_cnt), 128'(2));
        Nop      = 1'b0;
        ID_valid = 1'b1;
        tick();

        // Two 3-cycle stalls separated by a run cycle must not trip the watchdog.
        Nop = 1'b1;
        repeat (3) tick();
        Nop = 1'b0;
        tick();
        Nop = 1'b1;
        repeat (3) tick();
        check_eq("three_err", 128'(stall_err), 128'(0));
        check_eq("three_cnt", 128'(stall_cnt), 128'(8));
        Nop = 1'b0;
        tick();

        // Watchdog: fourth consecutive bubble sets the sticky flag.
        Nop = 1'b1;
        repeat (3) tick();
        check_eq("wd_pre_err", 128'(stall_err), 128'(0));
        tick();
        check_eq("wd_err", 128'(stall_err), 128'(1));
        check_eq("wd_cnt", 128'(stall_cnt), 128'(12));
        Nop = 1'b0;
        drive_id(1'b1, 8'h81, 5'd6, 5'd7, 5'd9, DataB);
        tick();
        check_eq("err_norm_valid", 128'(EX_valid), 128'(1));
        check_eq("err_norm_ctrl", 128'(ctrl_EX), 128'(8'h81));
        check_eq("err_sticky", 128'(stall_err), 128'(1));
        Nop = 1'b1;
        #1;
        check_eq("err_nop_pcwe", 128'(pcWe), 128'(0));
        tick();
        check_eq("err_nop_valid", 128'(EX_valid), 128'(0));
        check_eq("err_nop_cnt", 128'(stall_cnt), 128'(13));
        Nop   = 1'b0;
        Flush = 1'b1;
        #1;
        check_eq("err_fl_pcwe", 128'(pcWe), 128'(1));
        tick();
        check_eq("err_fl_cnt", 128'(stall_cnt), 128'(13));
        check_eq("err_fl_err", 128'(stall_err), 128'(1));
        Flush = 1'b0;

        // Async reset mid-stall with EX_valid high.
        drive_id(1'b1, 8'hC0, 5'd3, 5'd4, 5'd8, DataA);
        tick();
        Nop = 1'b1;
        tick();
        drive_id(1'b1, 8'hC0, 5'd3, 5'd4, 5'd8, DataA);
        Nop = 1'b0;
        tick();
        check_eq("ar_pre_valid", 128'(EX_valid), 128'(1));
        Nop = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_bubble("ar");
        check_eq("ar_cnt", 128'(stall_cnt), 128'(0));
        check_eq("ar_err", 128'(stall_err), 128'(0));
        check_eq("ar_we", 128'({pcWe, ifidWe}), 128'(2'b11));
        Nop = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        Nop   = 1'b1;
        #1;
        Nop   = 1'b0;
        tick();
        check_eq("ar_first_valid", 128'(EX_valid), 128'(1));
        check_eq("ar_first_data", data_EX, DataA);
        check_eq("ar_first_cnt", 128'(stall_cnt), 128'(0));

        // Saturation over 300 single-cycle pulses.
        for (int i = 0; i < 300; i++) begin
            Nop = 1'b1;
            tick();
            Nop = 1'b0;
            tick();
            if (i == 9) begin
                check_eq("sat_cnt10", 128'(stall_cnt), 128'(10));
            end
            if (i == 254) begin
                check_eq("sat_cnt255", 128'(stall_cnt), 128'(255));
            end
        end
        check_eq("sat_final", 128'(stall_cnt), 128'(255));
        check_eq("sat_err", 128'(stall_err), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge pipeline clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Nop  input  1  bubble request from the hazard unit (load-use or unresolved branch operand).
REQ-005 Flush  input  1  redirect (taken branch/jump); squash the instruction in ID.
REQ-006 ID_valid  input  1  ID holds a real instruction.
REQ-007 ctrl_ID  input  8  {RegWe, MemR, MemW, MemToReg, ALUSrc, ALUOp[2:0]}, bit7 = RegWe.
REQ-008 rfReSel1_ID, rfReSel2_ID, rfWeSel_ID  input  5 each  source and destination register numbers.
REQ-009 data_ID  input  128  {pc, imm, rd2, rd1}, 32 bits each, rd1 in bits 31:0.
REQ-010 EX_valid  output  1  EX holds a real instruction.
REQ-011 ctrl_EX  output  8  registered ctrl_ID; MemR_EX (bit6) goes to the hazard unit.
REQ-012 EX_rfReSel1, EX_rfReSel2, EX_rfWeSel  output  5 each  registered register numbers.
REQ-013 data_EX  output  128  registered data_ID.
REQ-014 pcWe  output  1  PC write enable (combinational).
REQ-015 ifidWe  output  1  IF/ID register write enable (combinational).
REQ-016 stall_cnt  output  8  saturating count of stall cycles.
REQ-017 stall_err  output  1  sticky watchdog flag for a stall that is too long.

Function
REQ-018 Priority SHALL be Flush > Nop > normal, evaluated each cycle.
REQ-019 Normal (Flush=0, Nop=0):
- every EX register SHALL load its ID input at the clock edge, EX_valid <= ID_valid;
- pcWe=1, ifidWe=1.
REQ-020 Bubble (Nop=1, Flush=0):
- EX SHALL load a bubble: EX_valid=0, ctrl_EX=0, all register numbers 0, data_EX=0;
- pcWe=0, ifidWe=0 in the same cycle, so PC and IF/ID hold.
REQ-021 Flush=1 (Nop ignored):
- EX SHALL load a bubble;
- pcWe=1, ifidWe=1.
REQ-022 Latency: ID to EX SHALL be exactly 1 cycle; pcWe and ifidWe SHALL have no register stage.
REQ-023 A bubble SHALL guarantee ctrl_EX[7]=0 and ctrl_EX[5]=0, so no register-file or memory write occurs.
REQ-024 The FSM SHALL have the states RUN, STALL1, STALL2, STALL3 and ERR.
REQ-025 FSM transitions on cycles with a bubble (Nop=1, Flush=0):
- RUN->STALL1, STALL1->STALL2, STALL2->STALL3;
- STALL3->ERR, and stall_err SHALL be set on that edge.
REQ-026 Any cycle with Nop=0 or Flush=1 SHALL return STALL1/2/3 to RUN.
REQ-027 ERR SHALL be sticky until reset; Nop and Flush SHALL still be honoured in ERR.
REQ-028 stall_cnt SHALL increment on every bubble cycle and saturate at 255 (no wrap).
REQ-029 Flush cycles SHALL NOT increment stall_cnt.
REQ-030 Nop=1 with ID_valid=0 SHALL still stall and count (the hazard unit is authoritative).

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock edge, clear:
- EX_valid, ctrl_EX, all EX register numbers, data_EX;
- stall_cnt and stall_err; FSM to RUN.
REQ-032 During reset pcWe and ifidWe SHALL be 1.
REQ-033 Reset asserted mid-stall SHALL abandon the stall; the first edge after deassertion SHALL behave as normal.
REQ-034 Reset deassertion SHALL be synchronised to clk outside this block.

Verification
REQ-035 Normal load: ID_valid=1, ctrl_ID=8'hC0, rfWeSel_ID=5'd8, rd1=32'h1234 -> next cycle EX_valid=1, ctrl_EX=8'hC0, EX_rfWeSel=8, data_EX[31:0]=32'h1234.
REQ-036 Load-use: Nop=1 for 1 cycle -> pcWe=ifidWe=0 that cycle; next cycle EX_valid=0, ctrl_EX=0; stall_cnt=1; FSM back to RUN.
REQ-037 Simultaneous Nop=1 and Flush=1 -> pcWe=ifidWe=1; EX bubble; stall_cnt unchanged.
REQ-038 Watchdog: Nop=1 for 4 consecutive cycles -> stall_err=1 after the 4th edge; it stays 1 after Nop=0 until rst_n=0.
REQ-039 Saturation: 300 single-cycle Nop pulses -> stall_cnt=255.
REQ-040 Async reset: rst_n=0 mid-stall with EX_valid=1 -> all outputs clear before the next clk edge; pcWe=1.
